// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit
// WIDTH-bit bitwise logic unit with one registered output stage and a valid/ready handshake.
// Eight bitwise ops on operand A and operand B, where B is either in2 or the accumulator
// (the previous accepted result). Registered zero/all-ones/parity flags travel with the
// result, and a saturating counter tracks accepted input transfers.

module bitwise_logic_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 acc_mode,
    input  logic                 acc_clear,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 all_ones,
    output logic                 parity,
    output logic [CNT_WIDTH-1:0] txn_count
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    op_e              op_sel;
    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] next_result;

    assign op_sel = op_e'(op);

    // The single output register can take a new value whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Pick operand B: in2 normally, the accumulator in accumulate mode (zeroed by acc_clear).
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        operand_b = in2;
        if (acc_mode) begin
            operand_b = acc_clear ? '0 : acc;
        end
    end

    // Compute the bitwise result for the selected op; NOT and PASS use operand A only.
    always_comb begin
        next_result = in1;
        case (op_sel)
            OP_NOT:  next_result = ~in1;
            OP_AND:  next_result = in1 & operand_b;
            OP_OR:   next_result = in1 | operand_b;
            OP_NAND: next_result = ~(in1 & operand_b);
            OP_NOR:  next_result = ~(in1 | operand_b);
            OP_XOR:  next_result = in1 ^ operand_b;
            OP_XNOR: next_result = ~(in1 ^ operand_b);
            OP_PASS: next_result = in1;
            default: next_result = in1;
        endcase
    end

    // Output register: load result and flags on accept, hold while stalled, drop valid when drained.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the values
        // from before the edge, independent of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            all_ones  <= 1'b0;
            parity    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= next_result;
            zero      <= (next_result == '0);
            all_ones  <= (next_result == '1);
            parity    <= ^next_result;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: follows every accepted result; acc_clear zeroes it only when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= next_result;
        end else if (acc_clear) begin
            acc <= '0;
        end
    end

    // Accepted-transfer counter, sticks at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_count <= '0;
        end else if (accept && (txn_count != CNT_MAX)) begin
            txn_count <= txn_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb_bitwise_logic_unit
// Directed vectors against a behavioural model of the logic unit (WIDTH=8, CNT_WIDTH=2),
// with literal expectations for the hand-computed cases.

module tb_bitwise_logic_unit;

    localparam int W  = 8;
    localparam int CW = 2;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'b000;
    logic          acc_mode = 1'b0;
    logic          acc_clear = 1'b0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;
    logic          all_ones;
    logic          parity;
    logic [CW-1:0] txn_count;

    int n_vec = 0;
    int n_mis = 0;

    bitwise_logic_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc_mode(acc_mode), .acc_clear(acc_clear),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .all_ones(all_ones), .parity(parity),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_result = 0;
    bit m_valid = 0;
    bit m_zero = 0;
    bit m_ones = 0;
    bit m_par = 0;
    int m_acc = 0;
    int m_count = 0;

    function automatic int op_model(input int o, input int a, input int b);
        int r;
        case (o)
            0: r = ~a;
            1: r = a & b;
            2: r = a | b;
            3: r = ~(a & b);
            4: r = ~(a | b);
            5: r = a ^ b;
            6: r = ~(a ^ b);
            default: r = a;
        endcase
        return r & ((1 << W) - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result = 0; m_valid = 0; m_zero = 0; m_ones = 0; m_par = 0;
            m_acc = 0; m_count = 0;
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                int b;
                int r;
                b = acc_mode ? (acc_clear ? 0 : m_acc) : int'(in2);
                r = op_model(int'(op), int'(in1), b);
                m_result = r;
                m_valid  = 1;
                m_zero   = (r == 0);
                m_ones   = (r == (1 << W) - 1);
                m_par    = ($countones(r) % 2) == 1;
                m_acc    = r;
                if (m_count < CNT_SAT) m_count++;
            end else begin
                if (m_valid && out_ready) m_valid = 0;
                if (acc_clear) m_acc = 0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("result", 32'(result), 32'(m_result));
            check("zero", 32'(zero), 32'(m_zero));
            check("all_ones", 32'(all_ones), 32'(m_ones));
            check("parity", 32'(parity), 32'(m_par));
            check("txn_count", 32'(txn_count), 32'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic am, input logic ac);
        in_valid  = 1'b1;
        op        = o;
        in1       = a;
        in2       = b;
        acc_mode  = am;
        acc_clear = ac;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 8'h5A; sweep_exp[1] = 8'h05; sweep_exp[2] = 8'hAF; sweep_exp[3] = 8'hFA;
        sweep_exp[4] = 8'h50; sweep_exp[5] = 8'hAA; sweep_exp[6] = 8'h55; sweep_exp[7] = 8'hA5;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst result", 32'(result), 0);
        check("rst flags", {29'd0, zero, all_ones, parity}, 0);
        check("rst txn_count", 32'(txn_count), 0);
        rst = 1'b0;
        #1;
        check("in_ready after rst", 32'(in_ready), 1);

        // First transaction, 1-cycle latency
        apply(3'b001, 8'hF0, 8'h3C, 1'b0, 1'b0);
        check("and result", 32'(result), 32'h30);
        check("and zero", 32'(zero), 0);
        check("and parity", 32'(parity), 0);
        check("and out_valid", 32'(out_valid), 1);

        // Op sweep
        for (int i = 0; i < 8; i++) begin
            apply(3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0);
            check($sformatf("sweep op%0d result", i), 32'(result), 32'(sweep_exp[i]));
            check($sformatf("sweep op%0d all_ones", i), 32'(all_ones), 0);
            check($sformatf("sweep op%0d zero", i), 32'(zero), 0);
        end

        // Back-pressure: hold for 3 cycles, new input not consumed
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'b001; in1 = 8'hFF; in2 = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold result", 32'(result), 32'hA5);
            check("hold out_valid", 32'(out_valid), 1);
            check("hold in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release result", 32'(result), 32'h0F);
        for (int i = 1; i <= 3; i++) begin
            apply(3'b101, 8'hF0, 8'(i), 1'b0, 1'b0);
            check("stream result", 32'(result), 32'(8'hF0 ^ 8'(i)));
        end

        // Drain: valid drops, result held
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain out_valid", 32'(out_valid), 0);
        check("drain result", 32'(result), 32'hF3);

        // Accumulator mode
        apply(3'b010, 8'h01, 8'hAA, 1'b1, 1'b1);
        check("acc or clear", 32'(result), 32'h01);
        apply(3'b101, 8'hFF, 8'hAA, 1'b1, 1'b0);
        check("acc xor", 32'(result), 32'hFE);
        apply(3'b011, 8'hFE, 8'hAA, 1'b1, 1'b0);
        check("acc nand", 32'(result), 32'h01);
        // accept wins over acc_clear for the state update
        apply(3'b010, 8'h3C, 8'h00, 1'b1, 1'b1);
        check("acc clear+accept", 32'(result), 32'h3C);
        apply(3'b101, 8'h00, 8'h00, 1'b1, 1'b0);
        check("acc kept", 32'(result), 32'h3C);
        // acc_clear on an idle cycle zeroes the accumulator
        in_valid = 1'b0; acc_clear = 1'b1;
        @(posedge clk);
        #1;
        acc_clear = 1'b0;
        apply(3'b010, 8'h00, 8'h00, 1'b1, 1'b0);
        check("acc idle clear", 32'(result), 0);

        // Flags
        apply(3'b101, 8'h77, 8'h77, 1'b0, 1'b0);
        check("xor zero", 32'(zero), 1);
        apply(3'b110, 8'h77, 8'h77, 1'b0, 1'b0);
        check("xnor all_ones", 32'(all_ones), 1);
        check("xnor parity", 32'(parity), 0);

        // Mid-stream async reset
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst result", 32'(result), 0);
        check("async rst flags", {29'd0, zero, all_ones, parity}, 0);
        check("async rst txn_count", 32'(txn_count), 0);
        @(posedge clk);
        #1;
        check("rst edge no output", 32'(out_valid), 0);
        rst = 1'b0;

        // Saturating counter
        for (int i = 0; i < 5; i++) begin
            apply(3'b001, 8'(i), 8'hFF, 1'b0, 1'b0);
            check("txn_count sat", 32'(txn_count), (i < 3) ? i + 1 : 3);
        end

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
